// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - RX sampler sequencing: gating, frame sync check, payload handoff, error counters
module rx_frame_ctrl #(
    parameter int                SAMPLE_W     = 80,
    parameter int                SYNC_W       = 8,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
    parameter int                HOLDOFF      = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         rx_signal,
    output logic                         sampler_signal,
    input  logic                         sampler_flag,
    input  logic [SAMPLE_W-1:0]          sampler_data,
    output logic [SAMPLE_W-SYNC_W-1:0]   frame_data,
    output logic                         frame_valid,
    input  logic                         frame_ready,
    output logic [7:0]                   sync_err_cnt,
    output logic [7:0]                   overrun_cnt
);

    localparam int          PAY_W     = SAMPLE_W - SYNC_W;
    localparam logic [7:0]  HOLD_LOAD = 8'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        S_DRAIN   = 3'd0,
        S_IDLE    = 3'd1,
        S_ARMED   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLDOFF = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic       gate_open;
    logic [7:0] hold_cnt;

    logic [SYNC_W-1:0] sync_field;
    logic              frame_done;
    logic              sync_ok;
    logic              transfer;
    logic              load;
    logic              overrun;

    assign sync_field = sampler_data[SAMPLE_W-1 -: SYNC_W];
    assign frame_done = (state == S_CAPTURE) && !sampler_flag;
    assign sync_ok    = (sync_field == SYNC_PATTERN);
    assign transfer   = frame_valid && frame_ready;
    // A drain on the same edge frees the single entry for the incoming frame.
    assign load       = frame_done && sync_ok && (!frame_valid || frame_ready);
    assign overrun    = frame_done && sync_ok && frame_valid && !frame_ready;

    assign sampler_signal = rx_signal & gate_open;

    always_comb begin
        state_nx = state;
        case (state)
            S_DRAIN:   if (!sampler_flag) state_nx = S_IDLE;
            S_IDLE:    if (enable) state_nx = S_ARMED;
            S_ARMED: begin
                if (sampler_flag)  state_nx = S_CAPTURE;
                else if (!enable)  state_nx = S_IDLE;
            end
            S_CAPTURE: if (!sampler_flag) state_nx = S_HOLDOFF;
            S_HOLDOFF: if (hold_cnt == 8'd0) state_nx = enable ? S_ARMED : S_IDLE;
            default:   state_nx = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_DRAIN;
            gate_open <= 1'b0;
            hold_cnt  <= 8'd0;
        end else begin
            state     <= state_nx;
            // Gate follows the state one edge late.
            gate_open <= (state == S_ARMED) || (state == S_CAPTURE);
            if (frame_done)
                hold_cnt <= HOLD_LOAD;
            else if (state == S_HOLDOFF && hold_cnt != 8'd0)
                hold_cnt <= hold_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
        end else begin
            if (load) begin
                frame_data  <= sampler_data[PAY_W-1:0];
                frame_valid <= 1'b1;
            end else if (transfer) begin
                frame_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_err_cnt <= 8'd0;
            overrun_cnt  <= 8'd0;
        end else begin
            if (frame_done && !sync_ok && sync_err_cnt != 8'hFF)
                sync_err_cnt <= sync_err_cnt + 8'd1;
            if (overrun && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Sequencing controller for the RX PCB sampling path. It gates the raw RX signal into the 80-sample shift sampler and arms the sampler only when the controller is ready. It detects frame completion from the sampler's flag, checks the leading sync bits, and hands the payload to downstream logic over a valid/ready handshake. Between frames it enforces a dead-time holdoff and keeps saturating error counters.

## Interface
- SAMPLE_W, 80: sampler width; must match the sampler output.
- SYNC_W, 8: leading bits checked as sync.
- SYNC_PATTERN, 8'hA5: required sync value; MSB must be 1, because a high bit starts capture.
- HOLDOFF, 40: clk cycles the gate stays closed after each frame; range 1..255.

Ports:
- clk  in  1  40 kHz sample clock, shared with the sampler.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 allows arming.
- rx_signal  in  1  raw output from the RX PCB.
- sampler_signal  out  1  gated signal to the sampler: rx_signal AND gate_open (combinational AND of a registered gate).
- sampler_flag  in  1  sampler busy flag.
- sampler_data  in  SAMPLE_W  sampler vector; bit SAMPLE_W-1 is the first sample.
- frame_data  out  SAMPLE_W-SYNC_W  payload, sampler_data[SAMPLE_W-SYNC_W-1:0].
- frame_valid  out  1  payload held and valid.
- frame_ready  in  1  consumer accepts.
- sync_err_cnt  out  8  count of frames with a bad sync field; saturates at 255.
- overrun_cnt  out  8  good frames dropped because the buffer was full; saturates at 255.

## Operation
State machine, one state register:
- DRAIN (reset state)
  - gate closed.
  - → IDLE when sampler_flag==0 is sampled. The sampler has no reset and can be mid-frame when reset deasserts.
- IDLE
  - gate closed.
  - → ARMED when enable==1.
- ARMED
  - gate open.
  - → CAPTURE on sampled sampler_flag==1.
  - → IDLE if enable==0 while sampler_flag==0.
- CAPTURE
  - gate open. enable is ignored; a started frame always completes.
  - On the first sampled sampler_flag==0, evaluate the frame and → HOLDOFF.
- HOLDOFF
  - gate closed; down-counter loaded with HOLDOFF-1.
  - When the counter reaches 0: → ARMED if enable==1, else → IDLE.

Frame evaluation (single edge on leaving CAPTURE):
- sync = sampler_data[SAMPLE_W-1 -: SYNC_W].
- sync != SYNC_PATTERN: sync_err_cnt +1 (saturating); no output load.
- sync match, buffer empty or being drained this edge: load frame_data, frame_valid=1.
- sync match, buffer full and not draining: frame dropped, overrun_cnt +1 (saturating); frame_data is unchanged.

Output buffer:
- Single entry.
- A transfer occurs on an edge where frame_valid && frame_ready.
- frame_data must stay stable while frame_valid==1 and no transfer has occurred.

## Timing
- Reset values:
  - state=DRAIN, gate closed, so sampler_signal=0.
  - frame_valid=0, frame_data=0, both counters=0, holdoff counter=0.
- Gate changes take effect on the edge after the state change (registered gate).
- Latency: frame_valid rises on the edge at which the controller first samples sampler_flag==0 in CAPTURE. That is 1 clk after the sampler deasserts its flag; sampler_data is complete at that point.
- Transfer and new-load on the same edge: the new frame is loaded, frame_valid stays 1, no overrun.
- Transfer with no new load: frame_valid=0 on that edge.
- Frame-to-frame minimum: HOLDOFF cycles closed plus 1 ARMED cycle before a new capture can start.
- enable dropped during HOLDOFF: the holdoff completes, then → IDLE.
- rst_n asserted mid-capture:
  - all outputs return to their reset values immediately (asynchronously).
  - after release, DRAIN waits out the sampler's residual frame; no output is produced for that frame.
- Counters saturate: 255 stays 255 and never wraps.

## Test plan
- Reset release with sampler_flag held 1 for 30 cycles → state remains DRAIN, sampler_signal=0 throughout; → IDLE on the cycle after the flag drops.
- enable=1, frame with sync 8'hA5 and payload 72'h0123456789ABCDEF01, frame_ready=1 → frame_valid pulses 1 cycle starting 1 clk after the flag falls, with frame_data=72'h0123456789ABCDEF01; sampler_signal is forced 0 for 40 cycles after the frame.
- Frame with sync 8'hA4 → no frame_valid; sync_err_cnt=1.
- frame_ready=0, two good frames → first frame held stable, second dropped, overrun_cnt=1; frame_ready raised on the same edge a third frame loads → valid stays 1, frame_data=third payload, overrun_cnt still 1.
- 300 bad-sync frames → sync_err_cnt=255, no wrap.
- enable deasserted mid-CAPTURE → frame completes and is output, then HOLDOFF, then IDLE with the gate closed; rst_n pulsed mid-capture → frame_valid=0, counters=0 immediately.
